// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the data-memory responder.
//   mem_state_t      : responder FSM states (IDLE, BUSY, DONE)
//   XLEN             : default data/address width
//   WORD_OFFSET_BITS : byte-offset bits below the word index
package riscv_pkg;
    localparam int XLEN             = 32;
    localparam int WORD_OFFSET_BITS = 2;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: DEPTH x XLEN word memory, synchronous write and synchronous read.
//   clk : clock
//   we  : write word idx with wd on the rising edge
//   re  : load word idx into rd on the rising edge
//   idx : word index
//   wd  : write data
//   rd  : registered read data, holds until the next read
module data_mem_array #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [XLEN-1:0]          wd,
    output logic [XLEN-1:0]          rd
);
    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wd;
        if (re) rd <= mem[idx];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle word load/store responder with stall, done and fault.
//   clk, rst          : clock, synchronous active-high reset
//   MemRead, MemWrite : load / store request from the control unit
//   addr, wdata       : byte address and store data
//   rdata             : load data, held until the next completed load (0 after reset or a faulted load)
//   stall             : holds the core while a request is accepted or in progress
//   done, fault       : one-cycle completion pulse; fault marks a rejected access
module data_mem_responder
    import riscv_pkg::*;
#(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            stall,
    output logic            done,
    output logic            fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t      state, next_state;
    logic [CW-1:0]   cnt;
    logic            op_rd, op_wr, fault_pend, have_data;
    logic [AW-1:0]   idx_q;
    logic [XLEN-1:0] wd_q, rd_word;
    logic            req, illegal, commit;

    assign req     = MemRead | MemWrite;
    assign illegal = (MemRead & MemWrite)
                   | (addr[WORD_OFFSET_BITS-1:0] != '0)
                   | ((addr >> (AW + WORD_OFFSET_BITS)) != '0);
    // rst gates the commit so a store in flight is dropped on the reset edge
    assign commit  = (state == BUSY) && (cnt == '0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = req ? (illegal ? DONE : BUSY) : IDLE;
            BUSY:    next_state = (cnt == '0) ? DONE : BUSY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            fault_pend <= 1'b0;
            have_data  <= 1'b0;
            op_rd      <= 1'b0;
            op_wr      <= 1'b0;
            idx_q      <= '0;
            wd_q       <= '0;
        end else begin
            if (state == IDLE && req) begin
                op_rd      <= MemRead;
                op_wr      <= MemWrite;
                idx_q      <= addr[AW+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
                wd_q       <= wdata;
                fault_pend <= illegal;
                cnt        <= illegal ? '0 : CW'(LATENCY - 1);
                if (illegal && MemRead) have_data <= 1'b0;
            end
            if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
            if (commit && op_rd) have_data <= 1'b1;
        end
    end

    data_mem_array #(.XLEN(XLEN), .DEPTH(DEPTH)) u_mem (
        .clk (clk),
        .we  (commit & op_wr),
        .re  (commit & op_rd),
        .idx (idx_q),
        .wd  (wd_q),
        .rd  (rd_word)
    );

    // the array's read register only updates on a committed load, so masking it
    // with have_data gives the zero-after-reset / zero-after-fault behaviour
    assign rdata = have_data ? rd_word : '0;
    assign stall = ((state == IDLE) & req) | (state == BUSY);
    assign done  = (state == DONE);
    assign fault = (state == DONE) & fault_pend;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (LATENCY=2 and LATENCY=1 instances).
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mr [2];
    logic        mw [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rdo [2];
    logic        st [2];
    logic        dn [2];
    logic        ft [2];
    bit          pd [2];
    logic [32:0] qa [$];
    logic [32:0] qb [$];
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.XLEN(32), .DEPTH(256), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]), .wdata(wd[0]),
        .rdata(rdo[0]), .stall(st[0]), .done(dn[0]), .fault(ft[0])
    );

    data_mem_responder #(.XLEN(32), .DEPTH(256), .LATENCY(1)) u_b (
        .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]), .wdata(wd[1]),
        .rdata(rdo[1]), .stall(st[1]), .done(dn[1]), .fault(ft[1])
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Issue one request in an IDLE cycle, queue its expected {fault, rdata}, and
    // measure how many cycles stall stays high (bounded).
    task automatic access(input int s, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit ef, input logic [31:0] er,
                          input int es, input string nm);
        int n;
        @(posedge clk); #1;
        mr[s] = r; mw[s] = w; ad[s] = a; wd[s] = d;
        if (s == 0) qa.push_back({ef, er});
        else        qb.push_back({ef, er});
        #1 chk({nm, " stall_cycle0"}, 32'(st[s]), 32'd1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            mr[s] = 1'b0; mw[s] = 1'b0; ad[s] = ~a; wd[s] = ~d;
            #1;
            if (!st[s]) break;
            n++;
        end
        chk({nm, " stall_len"}, 32'(n), 32'(es));
    endtask

    // Monitor: pops the scoreboard on every done pulse, independent of stimulus.
    always @(negedge clk) begin
        logic [32:0] e;
        for (int k = 0; k < 2; k++) begin
            if (dn[k]) begin
                vectors++;
                if (pd[k]) begin
                    errors++;
                    $display("FAIL done_width dut%0d: done high %0d cycles in a row, expected 1", k, 2);
                end
                vectors++;
                if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
                    errors++;
                    $display("FAIL unexpected_done dut%0d: done=1 with no access outstanding", k);
                end else begin
                    if (k == 0) e = qa.pop_front();
                    else        e = qb.pop_front();
                    if ({ft[k], rdo[k]} !== e) begin
                        errors++;
                        $display("FAIL response dut%0d: got fault=%b rdata=%h expected fault=%b rdata=%h",
                                 k, ft[k], rdo[k], e[32], e[31:0]);
                    end
                end
            end
            if (ft[k] && !dn[k]) begin
                vectors++;
                errors++;
                $display("FAIL fault_without_done dut%0d: fault=1 done=0", k);
            end
            pd[k] = dn[k];
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = '0; wd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_stall dut%0d", k), 32'(st[k]), 32'd0);
            chk($sformatf("reset_done dut%0d", k), 32'(dn[k]), 32'd0);
            chk($sformatf("reset_fault dut%0d", k), 32'(ft[k]), 32'd0);
            chk($sformatf("reset_rdata dut%0d", k), rdo[k], 32'd0);
        end

        // LATENCY=2 instance
        access(0, 0, 1, 32'h0,   32'h11111111, 0, 32'h0,        3, "store_0x0");
        access(0, 0, 1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        3, "store_0x10");
        access(0, 1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 3, "load_0x10");
        access(0, 1, 0, 32'h13,  32'h0,        1, 32'h0,        1, "load_misaligned");
        access(0, 1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 3, "reload_0x10");
        access(0, 0, 1, 32'h400, 32'hBAD0BAD0, 1, 32'hDEADBEEF, 1, "store_out_of_range");
        access(0, 1, 0, 32'h0,   32'h0,        0, 32'h11111111, 3, "load_0x0");
        access(0, 1, 1, 32'h10,  32'h55555555, 1, 32'h0,        1, "read_and_write");
        access(0, 1, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 3, "load_0x10_after_both");
        access(0, 0, 1, 32'h20,  32'hCAFEF00D, 0, 32'hDEADBEEF, 3, "store_0x20");

        // reset in the first BUSY cycle of a store: nothing completes, nothing written
        @(posedge clk); #1;
        mw[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h12345678;
        @(posedge clk); #1;
        mw[0] = 1'b0;
        rst = 1'b1;
        #1 chk("rst_busy stall", 32'(st[0]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_busy idle_stall", 32'(st[0]), 32'd0);
        chk("rst_busy done", 32'(dn[0]), 32'd0);
        chk("rst_busy fault", 32'(ft[0]), 32'd0);
        chk("rst_busy rdata", rdo[0], 32'd0);
        access(0, 1, 0, 32'h20, 32'h0, 0, 32'hCAFEF00D, 3, "load_0x20_after_rst");

        // LATENCY=1 instance: back-to-back accesses
        access(1, 0, 1, 32'h0, 32'hA5A5A5A5, 0, 32'h0,        2, "b_store_0x0");
        access(1, 0, 1, 32'h4, 32'h5A5A5A5A, 0, 32'h0,        2, "b_store_0x4");
        access(1, 1, 0, 32'h0, 32'h0,        0, 32'hA5A5A5A5, 2, "b_load_0x0");
        access(1, 1, 0, 32'h4, 32'h0,        0, 32'h5A5A5A5A, 2, "b_load_0x4");

        repeat (3) @(posedge clk);
        #1;
        chk("queue_a_drained", 32'(qa.size()), 32'd0);
        chk("queue_b_drained", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the RISC-V core; the memory-side counterpart to the main control unit's `MemRead`/`MemWrite` outputs. It accepts one word load or store per request from the datapath, models a configurable access latency, and holds the core with `stall` until the access completes. It also returns load data and reports illegal accesses. It sits between the datapath's ALU result/rs2 paths and the write-back mux feeding `MemtoReg`.

## Interface
Parameters:
- `XLEN`, 32, data and address width.
- `DEPTH`, 256, number of words in memory; power of two, at least 2.
- `LATENCY`, 2, number of BUSY cycles before the access commits; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `MemRead`  in  1  load request from the control unit.
- `MemWrite`  in  1  store request from the control unit.
- `addr`  in  XLEN  byte address (ALU result).
- `wdata`  in  XLEN  store data (rs2).
- `rdata`  out  XLEN  registered load data.
- `stall`  out  1  holds PC and pipeline while high.
- `done`  out  1  one-cycle pulse; the access has completed.
- `fault`  out  1  one-cycle pulse together with `done`; the access was rejected.

## Operation
The block has three states: IDLE, BUSY and DONE.

- **IDLE**
  - A request is present when `MemRead | MemWrite`.
  - `stall` is combinational: `stall = (state==IDLE) & (MemRead|MemWrite)`, plus 1 throughout BUSY.
  - On a request edge, the block latches `addr`, `wdata` and the operation.
- **Legality check**, performed in IDLE. A request is illegal if any of these hold:
  - `MemRead & MemWrite`;
  - `addr[1:0] != 0`;
  - any `addr` bit at or above `log2(DEPTH)+2` is nonzero.
- **Illegal request:** no access and no counter. The next state is DONE with `fault` pending.
- **Legal request:** the next state is BUSY, with the counter loaded to `LATENCY-1`.
- **BUSY**
  - `stall`=1.
  - The counter decrements each cycle.
  - On the edge where the counter equals 0, the access commits:
    - a store writes `wdata` to word `addr[log2(DEPTH)+1:2]`;
    - a load captures that word into `rdata`.
  - The next state is DONE.
- **DONE**
  - `stall`=0, `done`=1, and `fault`=1 for an illegal request.
  - Request inputs are ignored in this cycle, because the core advances on this edge.
  - The next state is IDLE.
- **`rdata`**
  - Holds its value until the next completed load.
  - A faulted load sets `rdata` to 0.
  - A store leaves `rdata` unchanged.
- Memory contents are not affected by `rst`.

## Timing
- Reset values: state IDLE, counter 0, `rdata`=0, `done`=0, `fault`=0. `stall` is 0 after reset unless a request is present.
- Legal access, with the request seen in cycle 0:
  - `stall` is high in cycles 0..LATENCY;
  - DONE occurs in cycle LATENCY+1;
  - `rdata` is valid from cycle LATENCY+1;
  - total stall is LATENCY+1 cycles.
- Illegal access: `stall` is high in cycle 0 only; `done` and `fault` are high in cycle 1.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, giving a minimum of LATENCY+2 cycles per access.
- Request inputs changing during BUSY are ignored, because the latched values are used.
- `rst` during BUSY or DONE:
  - the block returns to IDLE on that edge;
  - a pending store is discarded and memory is unchanged;
  - `done` and `fault` read 0 in the next cycle.
- Counter width: `$clog2(LATENCY)` bits, with a minimum of 1. It never wraps, because it is only decremented while nonzero.

## Structure
- Shared package `riscv_pkg`:
  - `mem_state_t` enum: IDLE, BUSY, DONE;
  - the `XLEN` constant;
  - the `WORD_OFFSET_BITS=2` constant.
- Sub-module `data_mem_array`:
  - DEPTH x XLEN;
  - synchronous write and synchronous read;
  - ports `clk`, `we`, `re`, `idx`, `wd`, `rd`.
- The responder owns the FSM, counter, request latches, legality check and the `rdata` register.

## Test plan
1. **Store then load.** `MemWrite` with addr 0x10 and wdata 0xDEADBEEF, then `MemRead` at addr 0x10.
   - Each access gives `stall` high for 3 cycles.
   - `done` pulses in cycle 3.
   - `rdata`=0xDEADBEEF in the load's DONE cycle.
2. **Misaligned load.** `MemRead` at addr 0x13.
   - `stall` is high for 1 cycle.
   - `done`=`fault`=1 in cycle 1.
   - `rdata`=0.
   - Memory is unchanged.
3. **Out-of-range store.** `MemWrite` at addr 0x400 with DEPTH=256.
   - `fault` pulses.
   - A subsequent load of addr 0x0 returns its prior value.
4. **Both requests high.** `MemRead` and `MemWrite` asserted together.
   - Fault path taken.
   - No write occurs.
5. **Reset mid-store.** Store 0x12345678 to 0x20, with `rst` asserted in BUSY cycle 1.
   - State is IDLE next cycle.
   - `done`=0.
   - A later load of 0x20 returns the old value.
6. **Back-to-back loads.** Loads at 0x0 then 0x4, with LATENCY=1.
   - Second `stall` begins in the cycle after the first DONE.
   - Each `done` pulse is exactly 1 cycle wide.
